// File: rtl/icache_assoc.sv
// icache_assoc: 2-way set-associative instruction cache with word-serial line refill.
//
// Parameters
//   SETS        number of sets (power of 2, >= 2)
//   LINE_WORDS  32-bit words per line (power of 2, >= 2)
// Ports
//   clk, rst              clock; synchronous active-high reset
//   rdy                   global enable; low freezes all state (if_valid forced low)
//   if_req, if_addr       fetch request (held until if_valid) and byte address
//   if_valid, if_data     one-cycle response pulse and instruction word
//   flush                 invalidate the whole cache, aborting any refill
//   mem_req, mem_addr     word read request to memory, word-aligned address
//   mem_valid, mem_data   returned word for the current mem_addr
module icache_assoc #(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int unsigned OB = $clog2(LINE_WORDS);
    localparam int unsigned IB = $clog2(SETS);
    localparam int unsigned TW = 32 - 2 - OB - IB;
    localparam int unsigned LW = 32 - 2 - OB;  // line address width (tag + index)

    typedef enum logic {StIdle, StRefill} state_e;

    state_e state_q, state_d;

    // Tag/valid/LRU state; LRU bit names the least recently used way.
    logic [SETS-1:0] vld0_q, vld1_q, lru_q;
    logic [TW-1:0]   tag_q  [2][SETS];
    logic [31:0]     data_q [2][SETS][LINE_WORDS];

    // Latched miss context.
    logic [LW-1:0] line_q;
    logic [OB-1:0] off_q;
    logic [OB-1:0] cnt_q;
    logic          victim_q;
    logic [31:0]   resp_q;

    logic [OB-1:0] req_off;
    logic [IB-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [IB-1:0] line_idx;
    logic [TW-1:0] line_tag;
    logic          hit0, hit1, hit, victim, last_word, is_req_word;
    logic          unused_addr_bits;

    assign req_off  = if_addr[2 +: OB];
    assign req_idx  = if_addr[2+OB +: IB];
    assign req_tag  = if_addr[31 -: TW];
    assign line_idx = line_q[IB-1:0];
    assign line_tag = line_q[IB +: TW];
    assign unused_addr_bits = ^if_addr[1:0];

    assign hit0 = vld0_q[req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1 = vld1_q[req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit  = hit0 || hit1;

    // Fill an empty way first (way 0 preferred), otherwise evict the LRU way.
    assign victim = !vld0_q[req_idx] ? 1'b0 :
                    !vld1_q[req_idx] ? 1'b1 : lru_q[req_idx];

    assign last_word   = (cnt_q == OB'(LINE_WORDS - 1));
    assign is_req_word = (cnt_q == off_q);

    assign mem_req  = (state_q == StRefill);
    assign mem_addr = {line_q, cnt_q, 2'b00};

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            if (flush) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle:   if (if_req && !hit) state_d = StRefill;
                    StRefill: if (mem_valid && last_word) state_d = StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_q   <= '0;
            vld1_q   <= '0;
            lru_q    <= '0;
            cnt_q    <= '0;
            if_valid <= 1'b0;
            if_data  <= '0;
        end else if (!rdy) begin
            if_valid <= 1'b0;
        end else if (flush) begin
            // Partial refill data already written is harmless: the way stays invalid.
            vld0_q   <= '0;
            vld1_q   <= '0;
            lru_q    <= '0;
            cnt_q    <= '0;
            if_valid <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_req) begin
                        if (hit) begin
                            if_valid       <= 1'b1;
                            if_data        <= data_q[hit1][req_idx][req_off];
                            lru_q[req_idx] <= !hit1;
                        end else begin
                            line_q   <= if_addr[31 -: LW];
                            off_q    <= req_off;
                            victim_q <= victim;
                            cnt_q    <= '0;
                        end
                    end
                end
                StRefill: begin
                    if (mem_valid) begin
                        data_q[victim_q][line_idx][cnt_q] <= mem_data;
                        if (is_req_word) resp_q <= mem_data;
                        cnt_q <= cnt_q + OB'(1);
                        if (last_word) begin
                            if (victim_q) vld1_q[line_idx] <= 1'b1;
                            else          vld0_q[line_idx] <= 1'b1;
                            tag_q[victim_q][line_idx] <= line_tag;
                            lru_q[line_idx]           <= !victim_q;
                            if_valid                  <= 1'b1;
                            // Requested word may be arriving on this very edge.
                            if_data <= is_req_word ? mem_data : resp_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed bench for icache_assoc (SETS=64, LINE_WORDS=4).
// Memory returns word_of(addr) for each requested address.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, flush, mem_valid;
    logic [31:0] if_addr, mem_data;
    logic        if_valid, mem_req;
    logic [31:0] if_data, mem_addr;

    int n_assert = 0;
    int n_fail   = 0;

    icache_assoc #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_data  (if_data),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_valid(mem_valid),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) + 32'h0123_4567;
    endfunction

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Request addr, expect a miss, serve the whole line, expect the response.
    task automatic fetch_miss(input logic [31:0] addr, input string name);
        logic [31:0] base;
        base    = {addr[31:4], 4'h0};
        if_req  = 1'b1;
        if_addr = addr;
        step();
        check({name, " miss no valid"}, {31'd0, if_valid}, 32'd0);
        check({name, " miss mem_req"}, {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check({name, " mem_addr"}, mem_addr, base + 32'(4 * i));
            mem_valid = 1'b1;
            mem_data  = word_of(base + 32'(4 * i));
            step();
            if (i < 3) check({name, " early valid"}, {31'd0, if_valid}, 32'd0);
        end
        mem_valid = 1'b0;
        check({name, " refill valid"}, {31'd0, if_valid}, 32'd1);
        check({name, " refill data"}, if_data, word_of(addr));
        check({name, " refill mem_req"}, {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
    endtask

    // Request addr, expect a single-cycle hit with no memory traffic.
    task automatic fetch_hit(input logic [31:0] addr, input string name);
        if_req  = 1'b1;
        if_addr = addr;
        step();
        check({name, " hit valid"}, {31'd0, if_valid}, 32'd1);
        check({name, " hit data"}, if_data, word_of(addr));
        check({name, " hit mem_req"}, {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; if_addr = '0; mem_data = '0;
        step();
        step();
        check("reset if_valid", {31'd0, if_valid}, 32'd0);
        check("reset if_data", if_data, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        step();

        // Cold miss then back-to-back hit in the same line.
        fetch_miss(32'h0000_1008, "cold");
        fetch_hit(32'h0000_100C, "cold next");
        step();
        check("idle no valid", {31'd0, if_valid}, 32'd0);

        // Flush in idle, then conflict/LRU in set 0.
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_miss(32'h0000_1000, "after flush");
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_miss(32'h0000_0000, "lru a");
        fetch_miss(32'h0000_0400, "lru b");
        fetch_hit(32'h0000_0000, "lru a hit");
        fetch_miss(32'h0000_0800, "lru c");
        fetch_hit(32'h0000_0000, "lru a kept");
        fetch_miss(32'h0000_0400, "lru b evicted");

        // Flush after two refill words; stray mem_valid in idle.
        if_req  = 1'b1;
        if_addr = 32'h0000_2000;
        step();
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1'b1;
            mem_data  = word_of(32'h0000_2000 + 32'(4 * i));
            step();
        end
        check("pre-flush mem_addr", mem_addr, 32'h0000_2008);
        mem_valid = 1'b0;
        flush     = 1'b1;
        if_req    = 1'b0;
        step();
        flush = 1'b0;
        check("flush mem_req", {31'd0, mem_req}, 32'd0);
        check("flush no valid", {31'd0, if_valid}, 32'd0);
        mem_valid = 1'b1;
        mem_data  = 32'hBAD0_BAD0;
        step();
        mem_valid = 1'b0;
        check("stray no valid", {31'd0, if_valid}, 32'd0);
        check("stray mem_req", {31'd0, mem_req}, 32'd0);
        fetch_miss(32'h0000_2000, "reflush 2000");

        // Flush coinciding with the final refill word wins.
        if_req  = 1'b1;
        if_addr = 32'h0000_7004;
        step();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_data  = word_of(32'h0000_7000 + 32'(4 * i));
            step();
        end
        mem_data = word_of(32'h0000_700C);
        flush    = 1'b1;
        if_req   = 1'b0;
        step();
        flush     = 1'b0;
        mem_valid = 1'b0;
        check("flush last no valid", {31'd0, if_valid}, 32'd0);
        check("flush last mem_req", {31'd0, mem_req}, 32'd0);
        fetch_miss(32'h0000_7004, "after flush last");

        // rdy low for three cycles mid-refill with mem_valid pulsing.
        if_req  = 1'b1;
        if_addr = 32'h0000_5004;
        step();
        mem_valid = 1'b1;
        mem_data  = word_of(32'h0000_5000);
        step();
        rdy      = 1'b0;
        mem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall mem_addr", mem_addr, 32'h0000_5004);
            check("stall mem_req", {31'd0, mem_req}, 32'd1);
            check("stall no valid", {31'd0, if_valid}, 32'd0);
        end
        rdy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check("resume mem_addr", mem_addr, 32'h0000_5000 + 32'(4 * i));
            mem_data = word_of(32'h0000_5000 + 32'(4 * i));
            step();
        end
        mem_valid = 1'b0;
        if_req    = 1'b0;
        check("resume valid", {31'd0, if_valid}, 32'd1);
        check("resume data", if_data, word_of(32'h0000_5004));
        fetch_hit(32'h0000_5000, "stall line word0");
        fetch_hit(32'h0000_500C, "stall line word3");

        // Reset mid-refill.
        fetch_miss(32'h0000_1010, "pre-rst fill");
        fetch_hit(32'h0000_1014, "pre-rst hit");
        if_req  = 1'b1;
        if_addr = 32'h0000_6000;
        step();
        mem_valid = 1'b1;
        mem_data  = word_of(32'h0000_6000);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        mem_valid = 1'b0;
        if_req    = 1'b0;
        check("rst no valid", {31'd0, if_valid}, 32'd0);
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst if_data", if_data, 32'd0);
        step();
        fetch_miss(32'h0000_1010, "post-rst miss");

        // Offset extremes.
        fetch_miss(32'h0000_3000, "offset 0");
        fetch_miss(32'h0000_400C, "offset 3");
        fetch_hit(32'h0000_3000, "offset 0 hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
